// File: rtl/ui_game_ctrl_if.sv
// Signal bundle between the cursor/stage front end (master) and the game controller (slave).
interface ui_game_ctrl_if;
  logic       click;
  logic [8:0] click_x;
  logic [7:0] click_y;
  logic       key_pickup;
  logic       light_pickup;
  logic       door_reach;
  logic       damage;
  logic [3:0] state;
  logic [1:0] key_find;
  logic [1:0] heart;
  logic [1:0] todo;
  logic [3:0] play_valid;
  logic       state_chg;

  modport master (
    output click, click_x, click_y, key_pickup, light_pickup, door_reach, damage,
    input  state, key_find, heart, todo, play_valid, state_chg
  );

  modport slave (
    input  click, click_x, click_y, key_pickup, light_pickup, door_reach, damage,
    output state, key_find, heart, todo, play_valid, state_chg
  );
endinterface

// File: rtl/ui_game_ctrl.sv
// Game/UI controller: menu navigation by hit-tested clicks, stage progress, lives and unlocks.
module ui_game_ctrl #(
  parameter int unsigned HEARTS  = 3,
  parameter logic [15:0] LOCKOUT = 16'd50000
) (
  input  logic          clk,
  input  logic          rst_n,
  ui_game_ctrl_if.slave ui
);

  typedef enum logic [3:0] {
    StTitle    = 4'd0,
    StStaff    = 4'd1,
    StStage1   = 4'd2,
    StSuccess1 = 4'd3,
    StStage2   = 4'd4,
    StSuccess2 = 4'd5,
    StStage3   = 4'd6,
    StSuccess3 = 4'd7,
    StFail     = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    TodoNone  = 2'd0,
    TodoKey   = 2'd1,
    TodoLight = 2'd2,
    TodoDoor  = 2'd3
  } todo_e;

  state_e      r_state, w_state_nx, r_fail_stage, w_fail_nx, w_enter_st;
  todo_e       r_todo, w_todo_nx;
  logic [1:0]  r_key, w_key_nx, r_heart, w_heart_nx;
  logic [3:0]  r_valid, w_valid_nx;
  logic [15:0] r_lock;
  logic        r_click_d, r_chg_pend, r_chg;
  logic        w_click_ok, w_x_in, w_btn_a, w_btn_b, w_btn_c, w_door_ok, w_enter;

  assign w_x_in  = (ui.click_x >= 9'd120) && (ui.click_x < 9'd200);
  assign w_btn_a = w_x_in && (ui.click_y >= 8'd120) && (ui.click_y < 8'd140);
  assign w_btn_b = w_x_in && (ui.click_y >= 8'd160) && (ui.click_y < 8'd180);
  assign w_btn_c = w_x_in && (ui.click_y >= 8'd200) && (ui.click_y < 8'd220);

  assign w_click_ok = ui.click && !r_click_d && (r_lock == 16'd0);
  assign w_door_ok  = ui.door_reach && (r_todo == TodoDoor);

  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_key;
    w_heart_nx = r_heart;
    w_todo_nx  = r_todo;
    w_valid_nx = r_valid;
    w_fail_nx  = r_fail_stage;
    w_enter    = 1'b0;
    w_enter_st = StStage1;
    unique case (r_state)
      StTitle: begin
        if (w_click_ok) begin
          if (w_btn_a) begin
            w_enter = 1'b1; w_enter_st = StStage1;
          end else if (w_btn_b && r_valid[2]) begin
            w_enter = 1'b1; w_enter_st = StStage2;
          end else if (w_btn_c && r_valid[3]) begin
            w_enter = 1'b1; w_enter_st = StStage3;
          end
        end
      end
      StStaff: if (w_click_ok) w_state_nx = StTitle;
      StSuccess1, StSuccess2: begin
        if (w_click_ok && w_btn_b) begin
          w_enter = 1'b1; w_enter_st = state_e'(r_state + 4'd1);
        end else if (w_click_ok && w_btn_c) begin
          w_state_nx = StTitle;
        end
      end
      StSuccess3: begin
        if (w_click_ok && w_btn_b)      w_state_nx = StStaff;
        else if (w_click_ok && w_btn_c) w_state_nx = StTitle;
      end
      StFail: begin
        if (w_click_ok && w_btn_b) begin
          w_enter = 1'b1; w_enter_st = r_fail_stage;
        end else if (w_click_ok && w_btn_c) begin
          w_state_nx = StTitle;
        end
      end
      StStage1, StStage2, StStage3: begin
        if (ui.key_pickup && (r_key != 2'd3)) begin
          w_key_nx = r_key + 2'd1;
          if (r_key == 2'd2) w_todo_nx = (r_state == StStage1) ? TodoDoor : TodoLight;
        end
        if (ui.light_pickup && (r_todo == TodoLight)) w_todo_nx = TodoDoor;
        // A successful door reach masks any damage in the same cycle.
        if (w_door_ok) begin
          w_state_nx = state_e'(r_state + 4'd1);
          w_todo_nx  = TodoNone;
          if (r_state == StStage1)      w_valid_nx[2] = 1'b1;
          else if (r_state == StStage2) w_valid_nx[3] = 1'b1;
        end else if (ui.damage) begin
          if (r_heart > 2'd1) begin
            w_heart_nx = r_heart - 2'd1;
          end else begin
            w_heart_nx = 2'd0;
            w_state_nx = StFail;
            w_todo_nx  = TodoNone;
          end
        end
      end
      default: ;
    endcase
    if (w_enter) begin
      w_state_nx = w_enter_st;
      w_heart_nx = 2'(HEARTS);
      w_key_nx   = 2'd0;
      w_todo_nx  = TodoKey;
      w_fail_nx  = w_enter_st;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StTitle;
      r_key        <= 2'd0;
      r_heart      <= 2'(HEARTS);
      r_todo       <= TodoNone;
      r_valid      <= 4'b0011;
      r_fail_stage <= StStage1;
      r_lock       <= 16'd0;
      r_click_d    <= 1'b0;
      r_chg_pend   <= 1'b0;
      r_chg        <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_key        <= w_key_nx;
      r_heart      <= w_heart_nx;
      r_todo       <= w_todo_nx;
      r_valid      <= w_valid_nx;
      r_fail_stage <= w_fail_nx;
      r_click_d    <= ui.click;
      if (w_state_nx != r_state) r_lock <= LOCKOUT - 16'd1;
      else if (r_lock != 16'd0)  r_lock <= r_lock - 16'd1;
      // state_chg trails the visible state update by one cycle.
      r_chg_pend   <= (w_state_nx != r_state);
      r_chg        <= r_chg_pend;
    end
  end

  assign ui.state      = r_state;
  assign ui.key_find   = r_key;
  assign ui.heart      = r_heart;
  assign ui.todo       = r_todo;
  assign ui.play_valid = r_valid;
  assign ui.state_chg  = r_chg;

endmodule

// File: tb/tb_ui_game_ctrl.sv
// Self-checking bench for ui_game_ctrl: directed scenarios plus a randomized soak against a rule model.
module tb_ui_game_ctrl;
  localparam int unsigned HEARTS  = 3;
  localparam logic [15:0] LOCKOUT = 16'd20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ui_game_ctrl_if ui ();

  ui_game_ctrl #(.HEARTS(HEARTS), .LOCKOUT(LOCKOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ui   (ui)
  );

  always #5 clk = ~clk;

  // Reference model state, plain integers.
  int m_state, m_key, m_heart, m_todo, m_valid, m_fail, m_lock, m_clickd, m_pend, m_chg;

  function automatic int hit(int x, int y);
    if (x < 120 || x >= 200) return 0;
    if (y >= 120 && y < 140) return 1;
    if (y >= 160 && y < 180) return 2;
    if (y >= 200 && y < 220) return 3;
    return 0;
  endfunction

  function automatic logic [14:0] exp_snap();
    return {4'(m_state), 2'(m_key), 2'(m_heart), 2'(m_todo), 4'(m_valid), 1'(m_chg)};
  endfunction

  function automatic logic [14:0] dut_snap();
    return {ui.state, ui.key_find, ui.heart, ui.todo, ui.play_valid, ui.state_chg};
  endfunction

  task automatic model_reset();
    m_state = 0; m_key = 0; m_heart = HEARTS; m_todo = 0; m_valid = 3;
    m_fail = 2; m_lock = 0; m_clickd = 0; m_pend = 0; m_chg = 0;
  endtask

  task automatic model_step();
    int  ns, nk, nh, nt, nv, nf, btn, est, k;
    bit  ok, enter;
    ok  = ui.click && !m_clickd && m_lock == 0;
    btn = hit(int'(ui.click_x), int'(ui.click_y));
    ns = m_state; nk = m_key; nh = m_heart; nt = m_todo; nv = m_valid; nf = m_fail;
    enter = 0; est = 0;
    if (m_state == 0) begin
      if (ok && btn == 1) begin enter = 1; est = 2; end
      else if (ok && btn == 2 && ((m_valid >> 2) & 1) == 1) begin enter = 1; est = 4; end
      else if (ok && btn == 3 && ((m_valid >> 3) & 1) == 1) begin enter = 1; est = 6; end
    end else if (m_state == 1) begin
      if (ok) ns = 0;
    end else if (m_state == 3 || m_state == 5) begin
      if (ok && btn == 2) begin enter = 1; est = m_state + 1; end
      else if (ok && btn == 3) ns = 0;
    end else if (m_state == 7) begin
      if (ok && btn == 2) ns = 1;
      else if (ok && btn == 3) ns = 0;
    end else if (m_state == 8) begin
      if (ok && btn == 2) begin enter = 1; est = m_fail; end
      else if (ok && btn == 3) ns = 0;
    end else begin
      k = m_state / 2;
      if (ui.key_pickup && m_key < 3) begin
        nk = m_key + 1;
        if (nk == 3) nt = (k == 1) ? 3 : 2;
      end
      if (ui.light_pickup && m_todo == 2) nt = 3;
      if (ui.door_reach && m_todo == 3) begin
        ns = m_state + 1; nt = 0;
        if (k < 3) nv = m_valid | (1 << (k + 1));
      end else if (ui.damage) begin
        if (m_heart > 1) nh = m_heart - 1;
        else begin nh = 0; ns = 8; nt = 0; end
      end
    end
    if (enter) begin ns = est; nh = HEARTS; nk = 0; nt = 1; nf = est; end
    if (ns != m_state) m_lock = LOCKOUT - 1;
    else if (m_lock > 0) m_lock = m_lock - 1;
    m_chg = m_pend;
    m_pend = (ns != m_state) ? 1 : 0;
    m_clickd = ui.click ? 1 : 0;
    m_state = ns; m_key = nk; m_heart = nh; m_todo = nt; m_valid = nv; m_fail = nf;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    ui.click = 0; ui.click_x = '0; ui.click_y = '0;
    ui.key_pickup = 0; ui.light_pickup = 0; ui.door_reach = 0; ui.damage = 0;
  endtask

  task automatic wait_lock();
    repeat (int'(LOCKOUT) + 1) tick();
  endtask

  task automatic click_at(int x, int y);
    ui.click_x = 9'(x); ui.click_y = 8'(y); ui.click = 1;
    tick();
    ui.click = 0;
  endtask

  task automatic pulse(bit kp, bit lp, bit dr, bit dm);
    ui.key_pickup = kp; ui.light_pickup = lp; ui.door_reach = dr; ui.damage = dm;
    tick();
    ui.key_pickup = 0; ui.light_pickup = 0; ui.door_reach = 0; ui.damage = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    rst_n = 0;
    #12;
    checks++;
    if (dut_snap() !== 15'b0000_00_11_00_0011_0) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", dut_snap(), 15'b0000_00_11_00_0011_0);
    end
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic test_locked_title();
    click_at(150, 170);
    checks++;
    if (ui.state !== 4'd0) begin
      errors++; $display("FAIL locked_stage2_click: state=%0d want 0", ui.state);
    end
    tick();
  endtask

  task automatic test_stage1_entry();
    click_at(150, 130);
    checks++;
    if ({ui.state, ui.heart, ui.todo, ui.key_find, ui.state_chg} !== {4'd2, 2'd3, 2'd1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL stage1_entry: state=%0d heart=%0d todo=%0d key=%0d chg=%0d",
               ui.state, ui.heart, ui.todo, ui.key_find, ui.state_chg);
    end
    tick();
    checks++;
    if (ui.state_chg !== 1'b1) begin errors++; $display("FAIL state_chg_pulse: got %0b want 1", ui.state_chg); end
    tick();
    checks++;
    if (ui.state_chg !== 1'b0) begin errors++; $display("FAIL state_chg_width: got %0b want 0", ui.state_chg); end
  endtask

  task automatic test_stage1_clear();
    repeat (3) pulse(1, 0, 0, 0);
    checks++;
    if ({ui.key_find, ui.todo} !== {2'd3, 2'd3}) begin
      errors++; $display("FAIL stage1_keys: key=%0d todo=%0d want 3 3", ui.key_find, ui.todo);
    end
    pulse(0, 0, 1, 0);
    checks++;
    if ({ui.state, ui.play_valid, ui.todo} !== {4'd3, 4'b0111, 2'd0}) begin
      errors++; $display("FAIL stage1_success: state=%0d valid=%b todo=%0d", ui.state, ui.play_valid, ui.todo);
    end
    wait_lock();
    click_at(150, 210);
    checks++;
    if (ui.state !== 4'd0) begin errors++; $display("FAIL success_back: state=%0d want 0", ui.state); end
    wait_lock();
    click_at(150, 170);
    checks++;
    if (ui.state !== 4'd4) begin errors++; $display("FAIL unlocked_stage2: state=%0d want 4", ui.state); end
  endtask

  task automatic test_stage2_light();
    repeat (3) pulse(1, 0, 0, 0);
    checks++;
    if (ui.todo !== 2'd2) begin errors++; $display("FAIL stage2_find_light: todo=%0d want 2", ui.todo); end
    pulse(0, 0, 1, 0);
    checks++;
    if (ui.state !== 4'd4) begin errors++; $display("FAIL early_door: state=%0d want 4", ui.state); end
    pulse(0, 1, 0, 0);
    checks++;
    if (ui.todo !== 2'd3) begin errors++; $display("FAIL light_pickup: todo=%0d want 3", ui.todo); end
    pulse(0, 0, 1, 0);
    checks++;
    if ({ui.state, ui.play_valid} !== {4'd5, 4'b1111}) begin
      errors++; $display("FAIL stage2_success: state=%0d valid=%b", ui.state, ui.play_valid);
    end
  endtask

  task automatic test_stage3_fail();
    wait_lock();
    click_at(150, 170);
    checks++;
    if (ui.state !== 4'd6) begin errors++; $display("FAIL enter_stage3: state=%0d want 6", ui.state); end
    for (int i = 0; i < 3; i++) begin
      pulse(0, 0, 0, 1);
      checks++;
      if (ui.heart !== 2'(2 - i)) begin
        errors++; $display("FAIL damage_%0d: heart=%0d want %0d", i, ui.heart, 2 - i);
      end
    end
    checks++;
    if ({ui.state, ui.todo} !== {4'd8, 2'd0}) begin
      errors++; $display("FAIL fail_state: state=%0d todo=%0d", ui.state, ui.todo);
    end
    wait_lock();
    click_at(150, 170);
    checks++;
    if ({ui.state, ui.heart} !== {4'd6, 2'd3}) begin
      errors++; $display("FAIL retry: state=%0d heart=%0d want 6 3", ui.state, ui.heart);
    end
  endtask

  task automatic test_door_damage();
    repeat (3) pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 1, 1);
    checks++;
    if ({ui.state, ui.heart} !== {4'd7, 2'd1}) begin
      errors++; $display("FAIL door_beats_damage: state=%0d heart=%0d want 7 1", ui.state, ui.heart);
    end
  endtask

  task automatic test_lockout();
    int changes;
    logic [3:0] prev;
    wait_lock();
    click_at(150, 170);
    checks++;
    if (ui.state !== 4'd1) begin errors++; $display("FAIL to_staff: state=%0d want 1", ui.state); end
    tick();
    click_at(10, 10);
    checks++;
    if (ui.state !== 4'd1) begin errors++; $display("FAIL lockout_drop: state=%0d want 1", ui.state); end
    wait_lock();
    changes = 0;
    prev = ui.state;
    ui.click_x = 9'd150; ui.click_y = 8'd130; ui.click = 1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ui.state !== prev) changes++;
      prev = ui.state;
    end
    ui.click = 0;
    tick();
    checks++;
    if (changes != 1 || ui.state !== 4'd0) begin
      errors++; $display("FAIL held_click: changes=%0d state=%0d want 1 0", changes, ui.state);
    end
  endtask

  task automatic test_reset_mid_stage();
    wait_lock();
    click_at(150, 170);
    pulse(1, 0, 0, 0);
    checks++;
    if ({ui.state, ui.key_find} !== {4'd4, 2'd1}) begin
      errors++; $display("FAIL pre_reset: state=%0d key=%0d want 4 1", ui.state, ui.key_find);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_snap() !== 15'b0000_00_11_00_0011_0) begin
      errors++; $display("FAIL async_reset: got %h want %h", dut_snap(), 15'b0000_00_11_00_0011_0);
    end
    model_reset();
    @(negedge clk); rst_n = 1;
    tick();
    click_at(150, 170);
    checks++;
    if (ui.state !== 4'd0) begin errors++; $display("FAIL unlock_cleared: state=%0d want 0", ui.state); end
  endtask

  task automatic test_random();
    int xs[4] = '{119, 120, 199, 200};
    int ys[12] = '{119, 120, 139, 140, 159, 160, 179, 180, 199, 200, 219, 220};
    int r;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ui.click = ~ui.click;
        r = $urandom_range(0, 9);
        if (r == 0) begin
          ui.click_x = 9'(xs[$urandom_range(0, 3)]);
          ui.click_y = 8'(ys[$urandom_range(0, 11)]);
        end else if (r == 1) begin
          ui.click_x = 9'($urandom_range(0, 319));
          ui.click_y = 8'($urandom_range(0, 239));
        end else begin
          ui.click_x = 9'($urandom_range(120, 199));
          ui.click_y = 8'(120 + 40 * $urandom_range(0, 2) + $urandom_range(0, 19));
        end
      end
      ui.key_pickup   = ($urandom_range(0, 5) == 0);
      ui.light_pickup = ($urandom_range(0, 5) == 0);
      ui.door_reach   = ($urandom_range(0, 5) == 0);
      ui.damage       = ($urandom_range(0, 11) == 0);
      tick();
      checks++;
      if (dut_snap() !== exp_snap()) begin
        errors++; $display("FAIL random_cycle_%0d: got %h want %h", i, dut_snap(), exp_snap());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_locked_title();
    test_stage1_entry();
    test_stage1_clear();
    test_stage2_light();
    test_stage3_fail();
    test_door_damage();
    test_lockout();
    test_reset_mid_stage();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
